chan_blk_reader: RTL and testbench

- Consumer end of the per-channel block interface (req/ack/16-bit dout with one registered FIFO read stage) driven by every channel processor in the chip.
- Round-robin arbitrates among NCH channels and moves one complete block at a time: control word plus L payload words.
- Forwards blocks as a framed 16-bit stream with backpressure to the downstream output FIFO/GTP packer.
- Validates each control word and counts protocol errors.

---
 rtl/chan_blk_reader.sv | 188 ++++++++++++++++++
 tb/tb_chan_blk_reader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_blk_reader.sv
// Round-robin block reader: pulls one framed block (control word + L payload words)
// at a time from NCH channel sources and forwards it as a sop/eop-qualified stream.
module chan_blk_reader #(
  parameter int NCH    = 16,
  parameter int CHBASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  input  logic [16*NCH-1:0] din,
  output logic [NCH-1:0]    ack,
  output logic [15:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              err_cw,
  output logic [15:0]       err_cnt,
  output logic              busy
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_HDR,
    S_GAP,
    S_DATA,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] g_q, g_d;
  logic [8:0]    rem_q, rem_d;
  logic          busy_q, busy_d;
  logic [15:0]   out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;
  logic          err_cw_q, err_cw_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  logic          ack_en;
  logic          any_req, hi_found;
  logic [IW-1:0] hi_idx, lo_idx;
  logic [15:0]   cur_word;
  logic [5:0]    exp_ch;
  logic          cw_ok;
  logic          slot_free;

  // Lowest requester at/above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    any_req  = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[k]) begin
        any_req = 1'b1;
        lo_idx  = IW'(k);
        if (IW'(k) >= rr_q) begin
          hi_found = 1'b1;
          hi_idx   = IW'(k);
        end
      end
    end
  end

  // Select is the registered grant, so the mux is stable from SETTLE onwards.
  always_comb begin
    cur_word = '0;
    for (int k = 0; k < NCH; k++) begin
      if (IW'(k) == g_q) cur_word = din[16*k +: 16];
    end
  end

  always_comb begin
    ack = '0;
    for (int k = 0; k < NCH; k++) begin
      if (IW'(k) == g_q) ack[k] = ack_en;
    end
  end

  assign exp_ch    = 6'(CHBASE) + 6'(g_q);
  assign cw_ok     = cur_word[15] && (cur_word[14:9] == exp_ch);
  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    g_d         = g_q;
    rem_d       = rem_q;
    busy_d      = busy_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    err_cw_d    = 1'b0;
    err_cnt_d   = err_cnt_q;
    ack_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          g_d     = hi_found ? hi_idx : lo_idx;
          busy_d  = 1'b1;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: state_d = S_HDR;
      S_HDR: begin
        if (slot_free) begin
          ack_en = 1'b1;
          if (cw_ok) begin
            out_data_d  = cur_word;
            out_valid_d = 1'b1;
            out_sop_d   = 1'b1;
            out_eop_d   = (cur_word[8:0] == 9'd0);
            rem_d       = cur_word[8:0];
            state_d     = (cur_word[8:0] == 9'd0) ? S_DONE : S_GAP;
          end else begin
            // Bad control word is consumed and dropped; the next attempt reads the following word.
            err_cw_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            state_d = S_DONE;
          end
        end
      end
      S_GAP: state_d = S_DATA;
      S_DATA: begin
        if (slot_free) begin
          ack_en      = 1'b1;
          out_data_d  = cur_word;
          out_valid_d = 1'b1;
          out_sop_d   = 1'b0;
          out_eop_d   = (rem_q == 9'd1);
          rem_d       = rem_q - 9'd1;
          state_d     = (rem_q == 9'd1) ? S_DONE : S_GAP;
        end
      end
      S_DONE: begin
        rr_d    = (g_q == IW'(NCH - 1)) ? '0 : g_q + 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      g_q         <= '0;
      rem_q       <= '0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      err_cw_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      g_q         <= g_d;
      rem_q       <= rem_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      err_cw_q    <= err_cw_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign err_cw    = err_cw_q;
  assign err_cnt   = err_cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_chan_blk_reader.sv
// Bench for chan_blk_reader: queue-backed channel sources, scoreboarded output stream.
module tb_chan_blk_reader;
  localparam int NCH    = 16;
  localparam int CHBASE = 0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req;
  logic [16*NCH-1:0] din;
  logic [NCH-1:0]    ack;
  logic [15:0]       out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sop;
  logic              out_eop;
  logic              err_cw;
  logic [15:0]       err_cnt;
  logic              busy;

  always #4 clk = ~clk;

  chan_blk_reader #(.NCH(NCH), .CHBASE(CHBASE)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din), .ack(ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .err_cw(err_cw),
    .err_cnt(err_cnt), .busy(busy)
  );

  typedef struct {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct {
    int          src;
    logic [15:0] cw;
    int          len;
    bit          fwd;
    int          stall_at;
    int          stall_len;
    int          exp_acks;
    int          exp_beats;
    int          exp_err;
  } vec_t;

  beat_t       exp_q[$];
  logic [15:0] srcq[NCH][$];
  bit          hold[NCH];
  logic [NCH-1:0] ack_s = '0;
  logic [5:0]  sop_ch[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  int ack_cnt[NCH];
  int last_ack[NCH];
  int out_cnt = 0, err_seen = 0, blk_id = 0, exp_err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Source model: a consumed word is replaced by junk for one cycle, then the next word.
  initial begin
    req = '0;
    din = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
        if (ack_s[i] && srcq[i].size() > 0) begin
          srcq[i].delete(0);
          hold[i] = 1'b1;
        end else begin
          hold[i] = 1'b0;
        end
        din[16*i +: 16] = hold[i] ? 16'hDEAD : ((srcq[i].size() > 0) ? srcq[i][0] : 16'h0000);
        req[i] = (srcq[i].size() > 0);
      end
    end
  end

  // Monitor on the falling edge; inputs only change shortly after rising edges.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      cyc++;
      ack_s = ack;
      if (rst_n) begin
        if (ack != '0) begin
          chk("ack_onehot", 32'($onehot(ack)), 1);
          chk("ack_slot_free", 32'(!(out_valid && !out_ready)), 1);
          for (int i = 0; i < NCH; i++) begin
            if (ack[i]) begin
              chk("ack_word_ready", 32'(srcq[i].size() > 0 && !hold[i]), 1);
              chk("ack_spacing", 32'(cyc - last_ack[i] >= 2), 1);
              last_ack[i] = cyc;
              ack_cnt[i]++;
            end
          end
        end
        if (err_cw) err_seen++;
        if (out_valid && out_ready) begin
          out_cnt++;
          if (out_sop) sop_ch.push_back(out_data[14:9]);
          chk("beat_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            chk("beat_data", 32'(out_data), 32'(b.data));
            chk("beat_sop", 32'(out_sop), 32'(b.sop));
            chk("beat_eop", 32'(out_eop), 32'(b.eop));
          end
        end
      end
    end
  end

  task automatic push_block(input int src, input logic [15:0] cw, input int len, input bit fwd);
    beat_t b;
    logic [15:0] w;
    srcq[src].push_back(cw);
    if (fwd) begin
      b.data = cw; b.sop = 1'b1; b.eop = (len == 0);
      exp_q.push_back(b);
      for (int k = 0; k < len; k++) begin
        w = {1'(k), 3'(blk_id), 4'(src), 8'(k)};
        srcq[src].push_back(w);
        b.data = w; b.sop = 1'b0; b.eop = (k == len - 1);
        exp_q.push_back(b);
      end
    end
    blk_id++;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NCH; i++) if (srcq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_counts();
    for (int i = 0; i < NCH; i++) ack_cnt[i] = 0;
    out_cnt  = 0;
    err_seen = 0;
  endtask

  task automatic wait_idle(input int stall_at, input int stall_len, output bit ok);
    bit stalled = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #2;
      if (stall_len > 0 && !stalled && out_cnt == stall_at) begin
        out_ready = 1'b0;
        repeat (stall_len) @(posedge clk);
        #2;
        out_ready = 1'b1;
        stalled   = 1'b1;
      end
      if (queues_empty() && exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    bit   ok;
    int   others;
    int   ord[4];

    vecs[0] = '{3,  16'h8605, 5, 1'b1, 0, 0,  6, 6, 0};
    vecs[1] = '{6,  16'h8C00, 0, 1'b1, 0, 0,  1, 1, 0};
    vecs[2] = '{2,  16'h8805, 0, 1'b0, 0, 0,  1, 0, 1};
    vecs[3] = '{2,  16'h8405, 5, 1'b1, 0, 0,  6, 6, 0};
    vecs[4] = '{7,  16'h8E08, 8, 1'b1, 3, 20, 9, 9, 0};
    vecs[5] = '{15, 16'h9E02, 2, 1'b1, 0, 0,  3, 3, 0};
    ord = '{0, 5, 15, 0};

    for (int i = 0; i < NCH; i++) begin
      last_ack[i] = -10;
      ack_cnt[i]  = 0;
    end
    out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sop", 32'(out_sop), 0);
    chk("rst_out_eop", 32'(out_eop), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_err_cw", 32'(err_cw), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    for (int i = 0; i < 6; i++) begin
      clear_counts();
      push_block(vecs[i].src, vecs[i].cw, vecs[i].len, vecs[i].fwd);
      wait_idle(vecs[i].stall_at, vecs[i].stall_len, ok);
      exp_err_cnt += vecs[i].exp_err;
      others = 0;
      for (int s = 0; s < NCH; s++) if (s != vecs[i].src) others += ack_cnt[s];
      chk($sformatf("v%0d_done", i), 32'(ok), 1);
      chk($sformatf("v%0d_acks", i), 32'(ack_cnt[vecs[i].src]), 32'(vecs[i].exp_acks));
      chk($sformatf("v%0d_ack_other", i), 32'(others), 0);
      chk($sformatf("v%0d_beats", i), 32'(out_cnt), 32'(vecs[i].exp_beats));
      chk($sformatf("v%0d_err_pulses", i), 32'(err_seen), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(exp_err_cnt));
    end

    // Round robin: pointer sits at 0 after source 15; source 0 has a second block queued.
    clear_counts();
    sop_ch.delete();
    push_block(0,  16'h8003, 3, 1'b1);
    push_block(5,  16'h8A02, 2, 1'b1);
    push_block(15, 16'h9E01, 1, 1'b1);
    push_block(0,  16'h8002, 2, 1'b1);
    wait_idle(0, 0, ok);
    chk("rr_done", 32'(ok), 1);
    chk("rr_blocks", 32'(sop_ch.size()), 4);
    for (int i = 0; i < 4 && i < sop_ch.size(); i++)
      chk($sformatf("rr_order%0d", i), 32'(sop_ch[i]), 32'(ord[i]));

    // Reset in the middle of a 10-word block, after payload word 3 is consumed.
    clear_counts();
    push_block(9, 16'h920A, 10, 1'b1);
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      #2;
      if (ack_cnt[9] >= 4) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_reached_word3", 32'(ok), 1);
    chk("mid_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out_sop", 32'(out_sop), 0);
    chk("mid_rst_out_eop", 32'(out_eop), 0);
    chk("mid_rst_out_data", 32'(out_data), 0);
    chk("mid_rst_err_cw", 32'(err_cw), 0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    srcq[9].delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_err_cnt", 32'(err_cnt), 0);
    chk("post_rst_no_ack9", 32'(ack_cnt[9]), 4);
    clear_counts();
    push_block(1, 16'h8203, 3, 1'b1);
    wait_idle(0, 0, ok);
    chk("post_rst_done", 32'(ok), 1);
    chk("post_rst_acks", 32'(ack_cnt[1]), 4);
    chk("post_rst_beats", 32'(out_cnt), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
